// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   BYTE_W                   : width of one memory transaction
//   ZERO_WORD                : bubble value for if_pc / if_inst
//   FETCH_FETCH, FETCH_READY : fetch FSM state encodings
//   fetch_state_t            : the complete FSM state as one packed struct,
//                              so a checker can bind to a single signal
package if_fetch_unit_pkg;

  localparam int          BYTE_W    = 8;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [0:0] FETCH_FETCH = 1'b0;
  localparam logic [0:0] FETCH_READY = 1'b1;

  typedef struct packed {
    logic [0:0] state;          // FETCH_FETCH / FETCH_READY
    logic [1:0] idx;            // byte index within the instruction word
    logic       redirect_pend;  // branch seen while a byte was outstanding
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Each 32-bit instruction is read as four
// little-endian byte transactions; the assembled pair is presented on
// if_pc / if_inst for the IF/ID register, and branches from ID redirect the PC.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   stall[5:0]         : pipeline stall vector; only stall[0] is used here
//   id_b_flag          : branch/jump taken in ID this cycle
//   id_b_target        : redirect target, valid with id_b_flag
//   mem_req, mem_addr  : byte read request and its address
//   mem_ready          : current byte completed, mem_rdata valid
//   mem_rdata          : returned byte
//   if_pc, if_inst     : presented instruction (zero = bubble)
//   stallreq_if        : fetch incomplete, stall stages 0-1
//
// Memory handshake: mem_req acts as valid and mem_ready as ready. A byte
// transfers on a clock edge where both are high. While mem_req is high
// and mem_ready is low, mem_addr does not change and the request is never
// withdrawn. mem_ready has no effect while mem_req is low.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              id_b_flag,
  input  logic [ADDR_W-1:0] id_b_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              stallreq_if
);

  fetch_state_t      fq;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_target;
  logic [23:0]       byte_buf;
  logic              in_fetch;

  // Only stall[0] controls this stage; the other bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  // Gated by rst so the request and stall request drop the moment reset
  // asserts, and the first request appears as soon as reset releases.
  assign in_fetch    = (fq.state == FETCH_FETCH) && !rst;
  assign mem_req     = in_fetch;
  assign stallreq_if = in_fetch;
  assign mem_addr    = in_fetch ? (pc + ADDR_W'(fq.idx)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.state         <= FETCH_FETCH;
      fq.idx           <= 2'd0;
      fq.redirect_pend <= 1'b0;
      pc               <= RESET_PC;
      pend_target      <= '0;
      byte_buf         <= '0;
      if_pc            <= '0;
      if_inst          <= '0;
    end else begin
      case (fq.state)
        FETCH_FETCH: begin
          if (mem_ready) begin
            if (id_b_flag) begin
              // Branch arriving with the completing byte: drop the byte
              // and restart at the new target immediately.
              pc               <= id_b_target;
              fq.idx           <= 2'd0;
              fq.redirect_pend <= 1'b0;
            end else if (fq.redirect_pend) begin
              // The byte that was in flight at the branch is now done; its
              // data belongs to the wrong path.
              pc               <= pend_target;
              fq.idx           <= 2'd0;
              fq.redirect_pend <= 1'b0;
            end else if (fq.idx == 2'd3) begin
              if_pc    <= pc;
              if_inst  <= {mem_rdata, byte_buf};
              fq.idx   <= 2'd0;
              fq.state <= FETCH_READY;
            end else begin
              case (fq.idx)
                2'd0:    byte_buf[7:0]   <= mem_rdata;
                2'd1:    byte_buf[15:8]  <= mem_rdata;
                default: byte_buf[23:16] <= mem_rdata;
              endcase
              fq.idx <= fq.idx + 2'd1;
            end
          end else if (id_b_flag) begin
            // Cannot abort the outstanding byte; remember where to go.
            // A later branch before completion simply overwrites the target.
            pend_target      <= id_b_target;
            fq.redirect_pend <= 1'b1;
          end
        end

        default: begin  // FETCH_READY
          if (id_b_flag) begin
            pc       <= id_b_target;
            fq.idx   <= 2'd0;
            if_pc    <= '0;
            if_inst  <= '0;
            fq.state <= FETCH_FETCH;
          end else if (!stall[0]) begin
            // IF/ID captures the held pair on this same edge.
            pc       <= pc + ADDR_W'(4);
            fq.idx   <= 2'd0;
            if_pc    <= '0;
            if_inst  <= '0;
            fq.state <= FETCH_FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed per-cycle vector table (including async
// reset pulses), then randomized wait states, stalls and branches checked
// against an instruction-level model of the PC sequence and memory contents.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        id_b_flag;
  logic [31:0] id_b_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] exp_q[$];

  if_fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .id_b_flag   (id_b_flag),
    .id_b_target (id_b_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .stallreq_if (stallreq_if)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory contents ----------------
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h00;
      32'd2:   return 8'h50;
      32'd3:   return 8'h00;
      default: begin
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ a[7:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem_byte(a3), mem_byte(a2), mem_byte(a1), mem_byte(a)};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"},  64'(mem_req),     64'd0);
    check({tag, ".addr"}, 64'(mem_addr),    64'd0);
    check({tag, ".pc"},   64'(if_pc),       64'd0);
    check({tag, ".inst"}, 64'(if_inst),     64'd0);
    check({tag, ".sreq"}, 64'(stallreq_if), 64'd0);
  endtask

  // Called at a falling edge: assert reset between clock edges, check that
  // outputs clear without waiting for a clock, then release at a falling edge.
  task automatic reset_pulse(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          pre_rst;
    bit          rdy;
    bit          stall0;
    bit          flag;
    logic [31:0] target;
    bit          e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    bit          e_sreq;
  } vec_t;

  vec_t vecs[$];

  // Cycle expected to be in FETCH, requesting byte address addr.
  function automatic vec_t fv(input bit rdy, input bit flag, input logic [31:0] target,
                              input logic [31:0] addr);
    vec_t v;
    v = '{pre_rst: 1'b0, rdy: rdy, stall0: 1'b0, flag: flag, target: target,
          e_req: 1'b1, e_addr: addr, e_pc: 32'd0, e_inst: 32'd0, e_sreq: 1'b1};
    return v;
  endfunction

  // Cycle expected to be in READY, presenting pc / inst.
  function automatic vec_t rv(input bit stall0, input bit flag, input logic [31:0] target,
                              input logic [31:0] pc, input logic [31:0] inst);
    vec_t v;
    v = '{pre_rst: 1'b0, rdy: 1'b0, stall0: stall0, flag: flag, target: target,
          e_req: 1'b0, e_addr: 32'd0, e_pc: pc, e_inst: inst, e_sreq: 1'b0};
    return v;
  endfunction

  task automatic fill_table();
    vec_t v;
    // zero-wait fetch of the first word, then 3 stalled READY cycles
    vecs.push_back(fv(1, 0, 0, 32'd0));
    vecs.push_back(fv(1, 0, 0, 32'd1));
    vecs.push_back(fv(1, 0, 0, 32'd2));
    vecs.push_back(fv(1, 0, 0, 32'd3));
    vecs.push_back(rv(1, 0, 0, 32'd0, 32'h0050_0013));
    vecs.push_back(rv(1, 0, 0, 32'd0, 32'h0050_0013));
    vecs.push_back(rv(1, 0, 0, 32'd0, 32'h0050_0013));
    vecs.push_back(rv(0, 0, 0, 32'd0, 32'h0050_0013));
    // advance to pc+4; branch to 0x100 while byte 2 waits
    vecs.push_back(fv(1, 0, 0, 32'd4));
    vecs.push_back(fv(1, 0, 0, 32'd5));
    vecs.push_back(fv(0, 1, 32'h100, 32'd6));
    vecs.push_back(fv(0, 0, 0, 32'd6));
    vecs.push_back(fv(1, 0, 0, 32'd6));
    vecs.push_back(fv(1, 0, 0, 32'h100));
    vecs.push_back(fv(1, 0, 0, 32'h101));
    vecs.push_back(fv(1, 0, 0, 32'h102));
    vecs.push_back(fv(1, 0, 0, 32'h103));
    // branch in READY beats the pc+4 advance
    vecs.push_back(rv(0, 1, 32'h40, 32'h100, mem_word(32'h100)));
    vecs.push_back(fv(1, 0, 0, 32'h40));
    vecs.push_back(fv(1, 0, 0, 32'h41));
    // async reset mid-fetch, restart at RESET_PC; branch with completing byte
    v = fv(1, 1, 32'hFFFF_FFFC, 32'd0);
    v.pre_rst = 1'b1;
    vecs.push_back(v);
    vecs.push_back(fv(1, 0, 0, 32'hFFFF_FFFC));
    vecs.push_back(fv(1, 0, 0, 32'hFFFF_FFFD));
    vecs.push_back(fv(1, 0, 0, 32'hFFFF_FFFE));
    vecs.push_back(fv(1, 0, 0, 32'hFFFF_FFFF));
    vecs.push_back(rv(0, 0, 0, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)));
    // pc+4 wraps to zero
    vecs.push_back(fv(1, 0, 0, 32'd0));
    vecs.push_back(fv(1, 0, 0, 32'd1));
    vecs.push_back(fv(1, 0, 0, 32'd2));
    vecs.push_back(fv(1, 0, 0, 32'd3));
    vecs.push_back(rv(1, 0, 0, 32'd0, 32'h0050_0013));
  endtask

  // ---------------- driver / main sequence ----------------
  initial begin
    logic [31:0] exp_pc;
    logic [63:0] exp_pair;
    int          wait_left;
    int          presented;
    bit          prev_hold;
    bit          prev_sreq;
    logic [31:0] prev_addr;

    rst         = 1'b1;
    stall       = 6'd0;
    id_b_flag   = 1'b0;
    id_b_target = 32'd0;
    mem_ready   = 1'b0;
    mem_rdata   = 8'd0;

    fill_table();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_rst) reset_pulse($sformatf("v%0d.rst", i));
      mem_ready   = vecs[i].rdy;
      stall       = {5'($urandom), vecs[i].stall0};
      id_b_flag   = vecs[i].flag;
      id_b_target = vecs[i].target;
      mem_rdata   = mem_byte(mem_addr);
      #1;
      check($sformatf("v%0d.req", i),  64'(mem_req),     64'(vecs[i].e_req));
      check($sformatf("v%0d.addr", i), 64'(mem_addr),    64'(vecs[i].e_addr));
      check($sformatf("v%0d.pc", i),   64'(if_pc),       64'(vecs[i].e_pc));
      check($sformatf("v%0d.inst", i), 64'(if_inst),     64'(vecs[i].e_inst));
      check($sformatf("v%0d.sreq", i), 64'(stallreq_if), 64'(vecs[i].e_sreq));
      @(posedge clk);
      @(negedge clk);
    end

    // Random phase: design is in READY here, so the pulse also checks that
    // a presented pair clears immediately.
    reset_pulse("rnd.rst");
    exp_pc    = 32'd0;
    wait_left = $urandom_range(0, 5);
    presented = 0;
    prev_hold = 1'b0;
    prev_sreq = 1'b1;
    prev_addr = 32'd0;

    repeat (4000) begin
      id_b_flag   = ($urandom_range(0, 19) == 0);
      id_b_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                : 32'($urandom_range(0, 1023));
      stall       = 6'($urandom);
      if (mem_req) begin
        mem_ready = (wait_left == 0);
        mem_rdata = mem_ready ? mem_byte(mem_addr) : 8'($urandom);
      end else begin
        mem_ready = 1'($urandom);
        mem_rdata = 8'($urandom);
      end
      #1;
      if (prev_hold)
        check("rnd.addr_stable", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, prev_addr});
      if (!stallreq_if) begin
        exp_q.push_back({exp_pc, mem_word(exp_pc)});
        exp_pair = exp_q.pop_front();
        check("rnd.pair", {if_pc, if_inst}, exp_pair);
        check("rnd.ready_req", 64'(mem_req), 64'd0);
        if (prev_sreq) presented++;
      end else begin
        check("rnd.bubble", {if_pc, if_inst}, 64'd0);
      end
      prev_hold = mem_req && !mem_ready;
      prev_addr = mem_addr;
      prev_sreq = stallreq_if;
      // Instruction-level model: a branch always decides the next presented
      // PC; otherwise a released READY moves to the next sequential word.
      if (id_b_flag) exp_pc = id_b_target;
      else if (!stallreq_if && !stall[0]) exp_pc = exp_pc + 32'd4;
      if (mem_req && mem_ready) wait_left = $urandom_range(0, 5);
      else if (mem_req) wait_left--;
      @(posedge clk);
      @(negedge clk);
    end
    check("rnd.progress", 64'(presented >= 50), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the `if_pc`/`if_inst` pair consumed by the IF/ID pipeline register. It reads each 32-bit instruction as four little-endian byte transactions over the shared byte-wide memory port. It raises a stall request until the instruction is assembled and honours the `stall` vector. It also redirects the PC on a branch resolved in ID.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset
ADDR_W, 32, address width (matches `InstAddrBus`)
INST_W, 32, instruction width (matches `InstBus`; fixed at 4 bytes)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
stall  in  6  pipeline stall vector; `stall[0]` holds the PC/fetch stage
id_b_flag  in  1  branch/jump taken, resolved in ID this cycle
id_b_target  in  ADDR_W  redirect target, valid with `id_b_flag`
mem_req  out  1  byte read request; held until accepted
mem_addr  out  ADDR_W  byte address of the current request
mem_ready  in  1  current request completed; `mem_rdata` valid this cycle
mem_rdata  in  8  returned byte
if_pc  out  ADDR_W  PC of the presented instruction (ZeroWord = bubble)
if_inst  out  INST_W  presented instruction (ZeroWord = bubble)
stallreq_if  out  1  fetch not complete; the control unit stalls stages 0-1

Behaviour:
- Reset (async, immediate): `pc=RESET_PC`, `idx=0`, `redirect_pend=0`, `state=FETCH`. Outputs `mem_req=0`, `mem_addr=0`, `if_pc=0`, `if_inst=0`, `stallreq_if=0`. The first request is issued in the first cycle after `rst` deasserts.
- States: FETCH, READY.
- FETCH:
  - `mem_req=1`, `mem_addr=pc+idx`, `stallreq_if=1`.
  - On `mem_ready`: `buf[8*idx+:8] <= mem_rdata`, `idx <= idx+1`.
  - When the byte with `idx==3` completes: `if_pc<=pc`, `if_inst<={rdata,buf[23:0]}`, then go to READY. `mem_req` drops on the same edge.
  - While in FETCH, `if_pc` and `if_inst` stay ZeroWord (bubble).
- READY:
  - `mem_req=0`, `stallreq_if=0`; `if_pc`/`if_inst` are held.
  - If `stall[0]==0`: `pc<=pc+4`, `idx<=0`, clear `if_pc`/`if_inst` to ZeroWord, go to FETCH. IF/ID captures the held pair on this same edge.
  - If `stall[0]==1`: hold everything.
- Minimum latency: 4 cycles per instruction (zero-wait memory) plus 1 READY cycle.
- Handshake: `mem_addr` is stable while `mem_req` is high and not yet ready. A transaction in progress is never aborted. `mem_ready` is ignored while `mem_req==0`.
- Branch redirect (`id_b_flag==1`), accepted regardless of `stall`:
  - FETCH, no request outstanding or `mem_ready` this cycle: `pc<=id_b_target`, `idx<=0`, discard partial bytes, stay in FETCH.
  - FETCH, request outstanding without `mem_ready`: latch the target, set `redirect_pend`, keep `mem_req`/`mem_addr` unchanged. When that byte completes, drop its data and restart at the target with `idx=0`.
  - READY: `pc<=id_b_target`, clear the output pair, go to FETCH. The redirect wins over the `pc+4` advance.
  - A new `id_b_flag` while `redirect_pend` is set overwrites the pending target (last wins).
- Target alignment is not checked: bytes are fetched at `target+0..3`. `pc+4` and `pc+idx` wrap modulo 2^ADDR_W.
- Wrong-path squash of the instruction already in IF/ID is performed by IF/ID; this block only redirects.

Decomposition:
- `Defines.vh` holds `ZeroWord`, `InstAddrBus`, `InstBus`, and new `FetchFetch`/`FetchReady` state encodings plus a `ByteBus` width macro.
- Single module; no sub-module warranted. The byte assembler is an indexed shift into `buf`.

Test Plan:
- Reset release, zero-wait memory returning bytes 13,00,50,00 at 0..3 -> `mem_addr` 0,1,2,3 on consecutive cycles; `if_inst=32'h0050_0013`, `if_pc=0`, `stallreq_if=0` in cycle 5; next request to addr 4.
- READY with `stall[0]=1` for 3 cycles -> outputs and `pc` held, `mem_req=0`; on `stall[0]=0` fetch resumes at `pc+4`.
- `id_b_flag` with target 0x100 while byte 2 is outstanding (`mem_ready` low) -> `mem_addr` stays `pc+2` until ready, byte discarded; next request is 0x100.
- `id_b_flag` target 0x40 in READY with `stall[0]=0` -> next `mem_addr=0x40`, not `pc+4`; `if_inst` cleared to 0.
- Async `rst` pulse mid-fetch between clock edges -> `mem_req`, `if_pc`, `if_inst`, `stallreq_if` go to 0 immediately; fetch restarts at RESET_PC.
- `pc=32'hFFFF_FFFC` advancing -> next `mem_addr=0` (wrap); random `mem_ready` wait states (0-5 cycles) produce the same `if_inst` values.
